processor_dispatcher: RTL and testbench



---
 rtl/processor_dispatcher.sv | 157 +++++++++++++++
 tb/tb_processor_dispatcher.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_dispatcher.sv
// Dispatcher between the opcode handler and NUM_PROCS motion processors: latches the selected
// processor for a whole command and routes its step/servo outputs to the shared controls.
`ifndef OP_BITS
`define OP_BITS 3
`endif
`ifndef STEPPER_X_BITS
`define STEPPER_X_BITS 16
`endif
`ifndef STEPPER_Y_BITS
`define STEPPER_Y_BITS 16
`endif
`ifndef OP_G00
`define OP_G00 0
`endif
`ifndef OP_G01
`define OP_G01 1
`endif
`ifndef OP_G02
`define OP_G02 2
`endif
`ifndef OP_G03
`define OP_G03 3
`endif

package Servo_p;
   typedef enum logic {SERVO_POS_UP = 1'b0, SERVO_POS_DOWN = 1'b1} ServoPosition_t;
endpackage

module processor_dispatcher #(
   parameter int OP_BITS        = `OP_BITS,
   parameter int STEPPER_X_BITS = `STEPPER_X_BITS,
   parameter int STEPPER_Y_BITS = `STEPPER_Y_BITS,
   parameter int NUM_PROCS      = 2,
   parameter int OP_PROC_MAP [2**OP_BITS] =
      '{`OP_G00: 0, `OP_G01: 0, `OP_G02: 1, `OP_G03: 1, default: -1},
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [OP_BITS-1:0]                op,
   input  logic                              trigger_in,
   input  logic                              stepper_done_in,
   input  logic [NUM_PROCS*STEPPER_X_BITS-1:0] procs_num_steps_x_in,
   input  logic [NUM_PROCS*STEPPER_Y_BITS-1:0] procs_num_steps_y_in,
   input  Servo_p::ServoPosition_t           procs_servo_pos_in [NUM_PROCS],
   input  logic [NUM_PROCS-1:0]              procs_done_in,
   output logic [NUM_PROCS-1:0]              procs_trigger_out,
   output logic [NUM_PROCS-1:0]              procs_stepper_done_out,
   output logic [STEPPER_X_BITS-1:0]         num_steps_x_out,
   output logic [STEPPER_Y_BITS-1:0]         num_steps_y_out,
   output Servo_p::ServoPosition_t           servo_pos_out,
   output logic                              done_out,
   output logic                              busy_out,
   output logic [1:0]                        error_out,
   output logic                              overrun_out
);

   localparam int NUM_OPS   = 2**OP_BITS;
   localparam int PROC_BITS = (NUM_PROCS > 1) ? $clog2(NUM_PROCS) : 1;
   localparam int CNT_BITS  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_UNSUP   = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   typedef enum logic [1:0] {IDLE, TRIG, BUSY, DONE} state_t;

   state_t                  state;
   logic [PROC_BITS-1:0]    sel;
   logic [CNT_BITS-1:0]     cnt;
   logic [CNT_BITS-1:0]     cnt_nxt;
   logic                    timeout_hit;
   Servo_p::ServoPosition_t hold_q;

   // Map entries are folded at elaboration into a valid flag and a narrowed index per op.
   logic [NUM_OPS-1:0]   op_valid;
   logic [PROC_BITS-1:0] op_sel [NUM_OPS];
   for (genvar i = 0; i < NUM_OPS; i++) begin : g_map
      localparam bit VALID = (OP_PROC_MAP[i] >= 0) && (OP_PROC_MAP[i] < NUM_PROCS);
      assign op_valid[i] = VALID;
      assign op_sel[i]   = VALID ? PROC_BITS'(OP_PROC_MAP[i]) : '0;
   end

   // Saturating watchdog count: never wraps back below the limit.
   assign cnt_nxt     = (cnt == '1) ? cnt : cnt + 1'b1;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (int'(cnt_nxt) >= TIMEOUT_CYCLES);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         sel               <= '0;
         cnt               <= '0;
         procs_trigger_out <= '0;
         done_out          <= 1'b0;
         error_out         <= ERR_OK;
         overrun_out       <= 1'b0;
         hold_q            <= Servo_p::SERVO_POS_UP;
      end else begin
         procs_trigger_out <= '0;
         done_out          <= 1'b0;
         if (trigger_in && (state != IDLE)) overrun_out <= 1'b1;
         case (state)
            IDLE: begin
               if (trigger_in) begin
                  overrun_out <= 1'b0;
                  if (op_valid[op]) begin
                     sel               <= op_sel[op];
                     error_out         <= ERR_OK;
                     procs_trigger_out <= NUM_PROCS'(1) << op_sel[op];
                     state             <= TRIG;
                  end else begin
                     error_out <= ERR_UNSUP;
                     done_out  <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            TRIG: begin
               cnt   <= '0;
               state <= BUSY;
            end
            BUSY: begin
               cnt    <= cnt_nxt;
               hold_q <= procs_servo_pos_in[sel];
               // Completion takes priority over a coincident timeout.
               if (procs_done_in[sel]) begin
                  error_out <= ERR_OK;
                  done_out  <= 1'b1;
                  state     <= DONE;
               end else if (timeout_hit) begin
                  error_out <= ERR_TIMEOUT;
                  done_out  <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy_out = (state != IDLE);

   always_comb begin
      procs_stepper_done_out = '0;
      num_steps_x_out        = '0;
      num_steps_y_out        = '0;
      servo_pos_out          = hold_q;
      if ((state == TRIG) || (state == BUSY)) begin
         num_steps_x_out = procs_num_steps_x_in[sel*STEPPER_X_BITS +: STEPPER_X_BITS];
         num_steps_y_out = procs_num_steps_y_in[sel*STEPPER_Y_BITS +: STEPPER_Y_BITS];
         servo_pos_out   = procs_servo_pos_in[sel];
      end
      if (state == BUSY) procs_stepper_done_out[sel] = stepper_done_in;
   end

endmodule

// File: tb/tb_processor_dispatcher.sv
// Scoreboard bench for processor_dispatcher: a command-level model predicts the per-cycle
// phase and completion of each command; a monitor compares the DUT against those predictions.
module tb_processor_dispatcher;
   import Servo_p::*;

   localparam int OPB = 3;
   localparam int XB  = 8;
   localparam int YB  = 6;
   localparam int NP  = 2;
   localparam int T   = 8;

   logic              clk;
   logic              rst_n;
   logic [OPB-1:0]    op;
   logic              trigger_in;
   logic              stepper_done_in;
   logic [NP*XB-1:0]  steps_x;
   logic [NP*YB-1:0]  steps_y;
   ServoPosition_t    servo_in [NP];
   logic [NP-1:0]     procs_done;
   logic [NP-1:0]     procs_trigger_out;
   logic [NP-1:0]     procs_stepper_done_out;
   logic [XB-1:0]     num_steps_x_out;
   logic [YB-1:0]     num_steps_y_out;
   ServoPosition_t    servo_pos_out;
   logic              done_out;
   logic              busy_out;
   logic [1:0]        error_out;
   logic              overrun_out;

   processor_dispatcher #(
      .OP_BITS        (OPB),
      .STEPPER_X_BITS (XB),
      .STEPPER_Y_BITS (YB),
      .NUM_PROCS      (NP),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk                    (clk),
      .reset                  (rst_n),
      .op                     (op),
      .trigger_in             (trigger_in),
      .stepper_done_in        (stepper_done_in),
      .procs_num_steps_x_in   (steps_x),
      .procs_num_steps_y_in   (steps_y),
      .procs_servo_pos_in     (servo_in),
      .procs_done_in          (procs_done),
      .procs_trigger_out      (procs_trigger_out),
      .procs_stepper_done_out (procs_stepper_done_out),
      .num_steps_x_out        (num_steps_x_out),
      .num_steps_y_out        (num_steps_y_out),
      .servo_pos_out          (servo_pos_out),
      .done_out               (done_out),
      .busy_out               (busy_out),
      .error_out              (error_out),
      .overrun_out            (overrun_out)
   );

   typedef struct {
      int         cyc;
      logic [1:0] err;
      logic       ovr;
   } done_t;

   int             n_tests = 0;
   int             n_fail  = 0;
   int             cyc     = 0;
   int             exp_phase [int];  // 1 TRIG, 2 BUSY, 3 DONE; absent means IDLE
   int             exp_sel   [int];
   done_t          done_q [$];
   ServoPosition_t hold_model = SERVO_POS_UP;
   logic [1:0]     err_model  = 2'd0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got stuck at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Processor assignment from the default op table: G00/G01 linear, G02/G03 circular.
   function automatic int proc_of(input int opc);
      if (opc == 0 || opc == 1) return 0;
      if (opc == 2 || opc == 3) return 1;
      return -1;
   endfunction

   task automatic randomize_data(input bit down);
      steps_x = (NP*XB)'($urandom);
      steps_y = (NP*YB)'($urandom);
      for (int i = 0; i < NP; i++)
         servo_in[i] = down ? SERVO_POS_DOWN : ServoPosition_t'($urandom_range(0, 1));
   endtask

   task automatic do_reset(input int cur);
      for (int k = cur; k <= cur + T + 3; k++) begin
         exp_phase.delete(k);
         exp_sel.delete(k);
      end
      void'(done_q.pop_back());
      #1;
      rst_n      = 1'b0;
      hold_model = SERVO_POS_UP;
      err_model  = 2'd0;
      #1;
      chk("rst_busy", busy_out, 0);
      chk("rst_trigger", procs_trigger_out, 0);
      chk("rst_stepper_done", procs_stepper_done_out, 0);
      chk("rst_steps_x", num_steps_x_out, 0);
      chk("rst_steps_y", num_steps_y_out, 0);
      chk("rst_servo", servo_pos_out, SERVO_POS_UP);
      chk("rst_done", done_out, 0);
      chk("rst_error", error_out, 0);
      chk("rst_overrun", overrun_out, 0);
      trigger_in      = 1'b0;
      procs_done      = '0;
      stepper_done_in = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // d: BUSY cycle on which the selected processor reports done (0 = never).
   task automatic run_cmd(input int opc, input int d, input bit early, input int ovr_k,
                          input int abort_k, input bit down);
      int    c;
      int    p;
      int    len;
      bit    ok;
      done_t e;
      p = proc_of(opc);
      @(posedge clk);
      #1;
      c          = cyc;
      op         = OPB'(opc);
      trigger_in = 1'b1;
      randomize_data(down);
      ok  = (d != 0) && (d <= T);
      len = ok ? d : T;
      if (p < 0) begin
         exp_phase[c+1] = 3;
         e.cyc = c + 1;
         e.err = 2'd1;
         e.ovr = 1'b0;
      end else begin
         exp_phase[c+1] = 1;
         exp_sel[c+1]   = p;
         for (int k = 1; k <= len; k++) begin
            exp_phase[c+1+k] = 2;
            exp_sel[c+1+k]   = p;
         end
         exp_phase[c+2+len] = 3;
         e.cyc = c + 2 + len;
         e.err = ok ? 2'd0 : 2'd2;
         e.ovr = (ovr_k >= 1) && (ovr_k <= len);
      end
      done_q.push_back(e);
      @(posedge clk);
      #1;
      trigger_in = 1'b0;
      randomize_data(down);
      if (p < 0) return;
      if (early) procs_done[p] = 1'b1;
      for (int k = 1; k <= len; k++) begin
         @(posedge clk);
         #1;
         procs_done        = '0;
         procs_done[1-p]   = 1'($urandom_range(0, 1));
         if (k == d) procs_done[p] = 1'b1;
         stepper_done_in   = 1'($urandom_range(0, 1));
         trigger_in        = (k == ovr_k);
         op                = OPB'($urandom_range(0, 7));
         randomize_data(down);
         if (k == abort_k) begin
            do_reset(c + 1 + k);
            return;
         end
      end
      @(posedge clk);
      #1;
      procs_done      = '0;
      trigger_in      = 1'b0;
      stepper_done_in = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   // Monitor: compares every output once per cycle on the falling edge.
   initial begin
      int    ph;
      int    s;
      bit    act;
      done_t e;
      forever begin
         @(negedge clk);
         ph  = exp_phase.exists(cyc) ? exp_phase[cyc] : 0;
         s   = exp_sel.exists(cyc) ? exp_sel[cyc] : 0;
         act = (ph == 1) || (ph == 2);
         chk("busy", busy_out, (ph != 0));
         chk("trigger", procs_trigger_out, (ph == 1) ? (1 << s) : 0);
         chk("stepper_done_route", procs_stepper_done_out,
             (ph == 2) ? (int'(stepper_done_in) << s) : 0);
         chk("steps_x", num_steps_x_out, act ? steps_x[s*XB +: XB] : 0);
         chk("steps_y", num_steps_y_out, act ? steps_y[s*YB +: YB] : 0);
         chk("servo", servo_pos_out, act ? servo_in[s] : hold_model);
         if (act) chk("error_running", error_out, 0);
         else if (ph == 0) chk("error_held", error_out, err_model);
         chk("done_pulse", done_out, (ph == 3));
         if (done_out) begin
            if (done_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = done_q.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("done_error", error_out, e.err);
               chk("done_overrun", overrun_out, e.ovr);
               err_model = e.err;
            end
         end
         if (ph == 2) hold_model = servo_in[s];
      end
   end

   initial begin
      rst_n           = 1'b0;
      op              = '0;
      trigger_in      = 1'b0;
      stepper_done_in = 1'b0;
      steps_x         = '0;
      steps_y         = '0;
      procs_done      = '0;
      for (int i = 0; i < NP; i++) servo_in[i] = SERVO_POS_UP;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_cmd(1, 8, 1'b0, 0, 0, 1'b1);   // linear, pen down, then hold in idle
      idle_cycles(3);
      run_cmd(2, 5, 1'b1, 0, 0, 1'b0);   // circular with decoys and an early done
      run_cmd(5, 0, 1'b0, 0, 0, 1'b0);   // unsupported op
      idle_cycles(2);
      run_cmd(3, 0, 1'b0, 0, 0, 1'b0);   // watchdog expiry
      run_cmd(0, 8, 1'b0, 0, 0, 1'b0);   // done coincides with the limit
      run_cmd(1, 6, 1'b0, 3, 0, 1'b1);   // overrun during BUSY
      idle_cycles(2);
      run_cmd(1, 0, 1'b0, 2, 5, 1'b1);   // reset mid-BUSY
      run_cmd(2, 3, 1'b0, 0, 0, 1'b0);   // accepted normally after reset

      for (int i = 0; i < 60; i++) begin
         run_cmd($urandom_range(0, 7), $urandom_range(0, T), 1'($urandom_range(0, 1)),
                 $urandom_range(0, T), 0, 1'($urandom_range(0, 1)));
         idle_cycles($urandom_range(0, 2));
      end

      idle_cycles(4);
      chk("queue_drained", done_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
